// File: rtl/imem_responder_pkg.sv
// Shared types and helpers for the instruction-memory responder.
//   imem_state_t  : responder FSM states (IDLE, WAIT)
//   imem_rsp_t    : one response word as held in the response FIFO
//   IMEM_ERR_INST : instruction word returned with an error response
//   imem_in_range : byte-address window check against a word-sized memory
package imem_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } imem_state_t;

    typedef struct packed {
        logic [31:0] inst;
        logic        err;
    } imem_rsp_t;

    localparam logic [31:0] IMEM_ERR_INST = 32'h0;

    // Latency counter width; LATENCY is limited to 1..4, so the counter
    // never has to hold more than 3.
    localparam int IMEM_CNT_W = 3;

    // True when addr lies in [base, base + 4*depth). Arguments are widened
    // to 64 bits so the upper bound cannot wrap for a window that ends at
    // the top of a 32-bit address space.
    function automatic logic imem_in_range(
        input logic [63:0] addr,
        input logic [63:0] base,
        input logic [63:0] depth
    );
        return (addr >= base) && (addr < base + (depth << 2));
    endfunction

endpackage

// File: rtl/imem_responder_if.sv
// Fetch/response/load bundle between the core (master) and the
// instruction-memory responder (slave).
//   req_valid/req_ready/req_addr    : fetch request channel
//   rsp_valid/rsp_ready/rsp_inst/rsp_err : response channel
//   load_en/load_addr/load_data     : program-image write port (no handshake)
//
// Handshake rule for both channels: a transfer happens on a rising clock
// edge where valid && ready are both high. A source holding valid keeps its
// payload stable until the transfer; ready may be high with valid low.
interface imem_responder_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_inst;
    logic              rsp_err;
    logic              load_en;
    logic [ADDR_W-1:0] load_addr;
    logic [31:0]       load_data;

    modport master (
        output req_valid, req_addr, rsp_ready, load_en, load_addr, load_data,
        input  req_ready, rsp_valid, rsp_inst, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, rsp_ready, load_en, load_addr, load_data,
        output req_ready, rsp_valid, rsp_inst, rsp_err
    );
endinterface

// File: rtl/imem_responder_rsp_fifo.sv
// Two-entry response FIFO for the instruction-memory responder.
//   clk, rst     : clock, asynchronous active-low reset
//   push_i       : write push_data_i at the tail (ignored when full, unless
//                  a pop happens on the same edge)
//   pop_i        : drop the head entry (no-op when empty)
//   head_o       : head entry, all-zero when empty
//   valid_o      : FIFO not empty
//   count_o      : number of stored entries (0..2)
module imem_rsp_fifo
    import imem_pkg::*;
#(
    parameter type T = imem_rsp_t
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push_i,
    input  T           push_data_i,
    input  logic       pop_i,
    output T           head_o,
    output logic       valid_o,
    output logic [1:0] count_o
);

    T           slot_q [2];
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] count_q, count_d;
    logic       do_push, do_pop;

    always_comb begin
        do_pop   = pop_i && (count_q != 2'd0);
        // A full FIFO still takes a push when the head leaves on the same edge.
        do_push  = push_i && ((count_q != 2'd2) || do_pop);
        wr_ptr_d = do_push ? ~wr_ptr_q : wr_ptr_q;
        rd_ptr_d = do_pop ? ~rd_ptr_q : rd_ptr_q;
        count_d  = count_q + {1'b0, do_push} - {1'b0, do_pop};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                slot_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) begin
                slot_q[wr_ptr_q] <= push_data_i;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign valid_o = (count_q != 2'd0);
    // Zero the head when empty so a drained FIFO never shows a stale word.
    assign head_o  = valid_o ? slot_q[rd_ptr_q] : '0;
    assign count_o = count_q;

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: memory end of the core's fetch path.
// Accepts one fetch at a time, returns the addressed 32-bit word (or an
// error response) after LATENCY cycles through a 2-entry response FIFO.
//   clk, rst          : clock, asynchronous active-low reset
//   bus (slave)       : fetch request, response and load channels
//   dbg_state_o       : FSM state
//   dbg_cnt_o         : latency down-counter
//   dbg_fifo_count_o  : response FIFO occupancy
// LATENCY must be in 1..4.
module imem_responder
    import imem_pkg::*;
#(
    parameter int                ADDR_W      = 32,
    parameter int                DEPTH_WORDS = 1024,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h8000_0000,
    parameter int                LATENCY     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    imem_responder_if.slave       bus,
    output imem_state_t           dbg_state_o,
    output logic [IMEM_CNT_W-1:0] dbg_cnt_o,
    output logic [1:0]            dbg_fifo_count_o
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [0:0] S_IDLE = IDLE;
    localparam logic [0:0] S_WAIT = WAIT;

    // Program image; deliberately not reset so it survives a core reset.
    logic [31:0] mem_q [DEPTH_WORDS];

    logic [0:0]            state_q, state_d;
    logic [IMEM_CNT_W-1:0] cnt_q, cnt_d;
    imem_rsp_t             held_q, held_d;

    logic             accept;
    logic             req_ok, load_ok;
    logic [IDX_W-1:0] req_idx, load_idx;
    imem_rsp_t        new_rsp;
    logic             push;
    imem_rsp_t        push_data;
    imem_rsp_t        head;
    logic             head_valid;
    logic [1:0]       fifo_count;

    // Address decode: aligned and inside the memory window.
    assign req_ok   = (bus.req_addr[1:0] == 2'b00) &&
                      imem_in_range(64'(bus.req_addr), 64'(BASE_ADDR), 64'(DEPTH_WORDS));
    assign load_ok  = (bus.load_addr[1:0] == 2'b00) &&
                      imem_in_range(64'(bus.load_addr), 64'(BASE_ADDR), 64'(DEPTH_WORDS));
    assign req_idx  = IDX_W'((bus.req_addr - BASE_ADDR) >> 2);
    assign load_idx = IDX_W'((bus.load_addr - BASE_ADDR) >> 2);

    // Bad loads are dropped silently. The fetch read below samples mem_q
    // before this write lands, so a same-edge load is not seen by the fetch.
    always_ff @(posedge clk) begin
        if (bus.load_en && load_ok) begin
            mem_q[load_idx] <= bus.load_data;
        end
    end

    always_comb begin
        new_rsp.inst = req_ok ? mem_q[req_idx] : IMEM_ERR_INST;
        new_rsp.err  = !req_ok;
    end

    // Ready depends only on registered state, so there is no path from
    // rsp_ready. Requiring a free slot at accept means a response always
    // has room when it is pushed.
    assign bus.req_ready = (state_q == S_IDLE) && (fifo_count < 2'd2);
    assign accept        = bus.req_valid && bus.req_ready;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        held_d    = held_q;
        push      = 1'b0;
        push_data = new_rsp;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        push = 1'b1;
                    end else begin
                        held_d  = new_rsp;
                        cnt_d   = IMEM_CNT_W'(LATENCY - 1);
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                cnt_d     = cnt_q - 1'b1;
                push_data = held_q;
                if (cnt_q == IMEM_CNT_W'(1)) begin
                    push    = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            held_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            held_q  <= held_d;
        end
    end

    imem_rsp_fifo #(
        .T (imem_rsp_t)
    ) u_rsp_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (bus.rsp_valid && bus.rsp_ready),
        .head_o      (head),
        .valid_o     (head_valid),
        .count_o     (fifo_count)
    );

    assign bus.rsp_valid = head_valid;
    assign bus.rsp_inst  = head.inst;
    assign bus.rsp_err   = head.err;

    assign dbg_state_o      = imem_state_t'(state_q);
    assign dbg_cnt_o        = cnt_q;
    assign dbg_fifo_count_o = fifo_count;

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: one instance with LATENCY=1, one with LATENCY=3,
// sharing clock and reset. Inputs change on the falling edge, outputs are
// checked on the falling edge.
module tb_imem_responder;
    import imem_pkg::*;

    localparam logic [31:0] BASE      = 32'h8000_0000;
    localparam logic [31:0] MEM_BYTES = 32'h0000_1000;
    localparam logic [31:0] W0        = 32'h0010_0093;
    localparam logic [31:0] W1        = 32'h0020_0113;
    localparam logic [31:0] W512      = 32'hA5A5_A5A5;
    localparam logic [31:0] W1023     = 32'h1234_5678;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    imem_responder_if #(.ADDR_W(32)) bus1 ();
    imem_responder_if #(.ADDR_W(32)) bus3 ();

    imem_state_t st1, st3;
    logic [2:0]  cnt1, cnt3;
    logic [1:0]  fc1, fc3;

    imem_responder #(.LATENCY(1)) dut1 (
        .clk              (clk),
        .rst              (rst),
        .bus              (bus1),
        .dbg_state_o      (st1),
        .dbg_cnt_o        (cnt1),
        .dbg_fifo_count_o (fc1)
    );

    imem_responder #(.LATENCY(3)) dut3 (
        .clk              (clk),
        .rst              (rst),
        .bus              (bus3),
        .dbg_state_o      (st3),
        .dbg_cnt_o        (cnt3),
        .dbg_fifo_count_o (fc3)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: word array plus queue of pending {err, inst}.
    logic [31:0] model_mem [1024];
    logic [32:0] exp_q [$];

    typedef struct {
        logic [31:0] addr;
        logic        exp_err;
        logic [31:0] exp_inst;
    } vec_t;
    vec_t vecs [10];

    task automatic chk_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    task automatic chk_word(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic addr_good(input logic [31:0] a);
        return (a[1:0] == 2'b00) && (a >= BASE) && (a < BASE + MEM_BYTES);
    endfunction

    function automatic logic [32:0] ref_fetch(input logic [31:0] a);
        int idx;
        if (!addr_good(a)) begin
            return {1'b1, 32'h0};
        end
        idx = int'((a - BASE) / 4);
        return {1'b0, model_mem[idx]};
    endfunction

    task automatic model_load(input logic [31:0] a, input logic [31:0] d);
        if (addr_good(a)) begin
            model_mem[int'((a - BASE) / 4)] = d;
        end
    endtask

    task automatic load_both(input logic [31:0] a, input logic [31:0] d);
        bus1.load_en = 1'b1; bus1.load_addr = a; bus1.load_data = d;
        bus3.load_en = 1'b1; bus3.load_addr = a; bus3.load_data = d;
        model_load(a, d);
        step();
        bus1.load_en = 1'b0;
        bus3.load_en = 1'b0;
    endtask

    function automatic logic [31:0] pick_addr();
        int sel;
        sel = $urandom_range(0, 9);
        if (sel < 7) return BASE + 32'(4 * $urandom_range(0, 1023));
        if (sel == 7) return BASE + 32'(4 * $urandom_range(0, 1023)) + 32'($urandom_range(1, 3));
        if (sel == 8) return BASE + MEM_BYTES + 32'(4 * $urandom_range(0, 255));
        return 32'h7FFF_F000 + 32'(4 * $urandom_range(0, 1023));
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        logic [31:0] w;
        logic        acc;
        logic [32:0] fetched;

        bus1.req_valid = 1'b0; bus1.req_addr = '0; bus1.rsp_ready = 1'b1;
        bus1.load_en = 1'b0; bus1.load_addr = '0; bus1.load_data = '0;
        bus3.req_valid = 1'b0; bus3.req_addr = '0; bus3.rsp_ready = 1'b1;
        bus3.load_en = 1'b0; bus3.load_addr = '0; bus3.load_data = '0;

        // ---- reset ----
        #2 rst = 1'b0;
        @(negedge clk);
        chk_bit("rst_rsp_valid1", bus1.rsp_valid, 1'b0);
        chk_word("rst_rsp_inst1", bus1.rsp_inst, 32'h0);
        chk_bit("rst_rsp_err1", bus1.rsp_err, 1'b0);
        chk_word("rst_fifo_count1", 32'(fc1), 32'd0);
        chk_bit("rst_rsp_valid3", bus3.rsp_valid, 1'b0);
        chk_word("rst_cnt3", 32'(cnt3), 32'd0);
        chk_bit("rst_state3_idle", st3 == IDLE, 1'b1);
        step();
        rst = 1'b1;
        chk_bit("rst_req_ready1", bus1.req_ready, 1'b1);
        chk_bit("rst_req_ready3", bus3.req_ready, 1'b1);

        // ---- program image ----
        for (int i = 0; i < 1024; i++) begin
            w = (i == 0) ? W0 : (i == 1) ? W1 : (i == 512) ? W512 : (i == 1023) ? W1023 : $urandom;
            load_both(BASE + 32'(4 * i), w);
        end
        // Bad loads must be dropped; the table below re-reads words 0 and 1.
        load_both(BASE + MEM_BYTES, 32'hBAD0_BAD0);
        load_both(BASE + 32'h6, 32'hBAD1_BAD1);

        // ---- table-driven single fetches, LATENCY=1 ----
        vecs[0] = '{32'h8000_0000, 1'b0, W0};
        vecs[1] = '{32'h8000_0004, 1'b0, W1};
        vecs[2] = '{32'h8000_0FFC, 1'b0, W1023};
        vecs[3] = '{32'h8000_0800, 1'b0, W512};
        vecs[4] = '{32'h8000_0002, 1'b1, 32'h0};
        vecs[5] = '{32'h7FFF_FFFC, 1'b1, 32'h0};
        vecs[6] = '{32'h8000_1000, 1'b1, 32'h0};
        vecs[7] = '{32'h8000_0001, 1'b1, 32'h0};
        vecs[8] = '{32'hFFFF_FFFC, 1'b1, 32'h0};
        vecs[9] = '{32'h0000_0000, 1'b1, 32'h0};
        for (int v = 0; v < 10; v++) begin
            bus1.req_valid = 1'b1;
            bus1.req_addr  = vecs[v].addr;
            chk_bit($sformatf("tbl%0d_req_ready", v), bus1.req_ready, 1'b1);
            step();
            bus1.req_valid = 1'b0;
            chk_bit($sformatf("tbl%0d_rsp_valid", v), bus1.rsp_valid, 1'b1);
            chk_bit($sformatf("tbl%0d_rsp_err", v), bus1.rsp_err, vecs[v].exp_err);
            chk_word($sformatf("tbl%0d_rsp_inst", v), bus1.rsp_inst, vecs[v].exp_inst);
            step();
            chk_bit($sformatf("tbl%0d_drained", v), bus1.rsp_valid, 1'b0);
        end

        // ---- back-to-back fetches, LATENCY=1 ----
        bus1.req_valid = 1'b1; bus1.req_addr = 32'h8000_0000;
        step();
        bus1.req_addr = 32'h8000_0004;
        chk_bit("b2b_ready2", bus1.req_ready, 1'b1);
        chk_bit("b2b_valid1", bus1.rsp_valid, 1'b1);
        chk_word("b2b_inst1", bus1.rsp_inst, W0);
        step();
        bus1.req_valid = 1'b0;
        chk_bit("b2b_valid2", bus1.rsp_valid, 1'b1);
        chk_bit("b2b_err2", bus1.rsp_err, 1'b0);
        chk_word("b2b_inst2", bus1.rsp_inst, W1);
        step();
        chk_bit("b2b_empty", bus1.rsp_valid, 1'b0);

        // ---- back-pressure, LATENCY=1 ----
        bus1.rsp_ready = 1'b0;
        bus1.req_valid = 1'b1; bus1.req_addr = 32'h8000_0000;
        step();
        bus1.req_addr = 32'h8000_0004;
        chk_bit("bp_ready_second", bus1.req_ready, 1'b1);
        step();
        bus1.req_addr = 32'h8000_0FFC;
        chk_bit("bp_ready_full", bus1.req_ready, 1'b0);
        chk_word("bp_count_full", 32'(fc1), 32'd2);
        step();
        chk_bit("bp_ready_held", bus1.req_ready, 1'b0);
        chk_word("bp_count_held", 32'(fc1), 32'd2);
        chk_word("bp_head_stable", bus1.rsp_inst, W0);
        bus1.rsp_ready = 1'b1;
        step();
        chk_bit("bp_ready_after_pop", bus1.req_ready, 1'b1);
        chk_word("bp_count_after_pop", 32'(fc1), 32'd1);
        chk_word("bp_head2", bus1.rsp_inst, W1);
        step();
        bus1.req_valid = 1'b0;
        chk_word("bp_count_pushpop", 32'(fc1), 32'd1);
        chk_word("bp_head3", bus1.rsp_inst, W1023);
        step();
        chk_bit("bp_drained", bus1.rsp_valid, 1'b0);

        // ---- LATENCY=3 timing ----
        bus3.req_valid = 1'b1; bus3.req_addr = 32'h8000_0000;
        chk_bit("l3_ready0", bus3.req_ready, 1'b1);
        step();
        bus3.req_addr = 32'h8000_0004;
        chk_bit("l3_ready1", bus3.req_ready, 1'b0);
        chk_bit("l3_valid1", bus3.rsp_valid, 1'b0);
        chk_bit("l3_state_wait", st3 == WAIT, 1'b1);
        chk_word("l3_cnt1", 32'(cnt3), 32'd2);
        step();
        chk_bit("l3_ready2", bus3.req_ready, 1'b0);
        chk_bit("l3_valid2", bus3.rsp_valid, 1'b0);
        chk_word("l3_cnt2", 32'(cnt3), 32'd1);
        step();
        chk_bit("l3_valid3", bus3.rsp_valid, 1'b1);
        chk_word("l3_inst3", bus3.rsp_inst, W0);
        chk_bit("l3_ready3", bus3.req_ready, 1'b1);
        step();
        bus3.req_valid = 1'b0;
        chk_bit("l3_valid4", bus3.rsp_valid, 1'b0);
        chk_bit("l3_ready4", bus3.req_ready, 1'b0);
        step();
        chk_bit("l3_valid5", bus3.rsp_valid, 1'b0);
        step();
        chk_bit("l3_valid6", bus3.rsp_valid, 1'b1);
        chk_word("l3_inst6", bus3.rsp_inst, W1);
        step();
        chk_bit("l3_drained", bus3.rsp_valid, 1'b0);

        // ---- same-edge load and fetch ----
        bus1.load_en = 1'b1; bus1.load_addr = BASE; bus1.load_data = 32'hDEAD_BEEF;
        bus3.load_en = 1'b1; bus3.load_addr = BASE; bus3.load_data = 32'hDEAD_BEEF;
        bus1.req_valid = 1'b1; bus1.req_addr = BASE;
        step();
        model_load(BASE, 32'hDEAD_BEEF);
        bus1.load_en = 1'b0; bus3.load_en = 1'b0;
        bus1.req_valid = 1'b0;
        chk_word("same_edge_old", bus1.rsp_inst, W0);
        step();
        bus1.req_valid = 1'b1; bus1.req_addr = BASE;
        step();
        bus1.req_valid = 1'b0;
        chk_word("same_edge_new", bus1.rsp_inst, 32'hDEAD_BEEF);
        step();
        load_both(BASE, W0);

        // ---- reset while WAIT with one FIFO entry, LATENCY=3 ----
        bus3.rsp_ready = 1'b0;
        bus3.req_valid = 1'b1; bus3.req_addr = BASE;
        step();
        bus3.req_valid = 1'b0;
        step();
        step();
        bus3.req_valid = 1'b1; bus3.req_addr = 32'h8000_0004;
        step();
        bus3.req_valid = 1'b0;
        chk_bit("rmid_state_wait", st3 == WAIT, 1'b1);
        chk_word("rmid_count1", 32'(fc3), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk_bit("rmid_valid_now", bus3.rsp_valid, 1'b0);
        chk_word("rmid_inst_now", bus3.rsp_inst, 32'h0);
        chk_word("rmid_count_now", 32'(fc3), 32'd0);
        chk_bit("rmid_state_idle", st3 == IDLE, 1'b1);
        chk_word("rmid_cnt_now", 32'(cnt3), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        bus3.rsp_ready = 1'b1;
        chk_bit("rmid_ready_after", bus3.req_ready, 1'b1);
        for (int k = 0; k < 4; k++) begin
            chk_bit($sformatf("rmid_no_stale%0d", k), bus3.rsp_valid, 1'b0);
            step();
        end
        bus3.req_valid = 1'b1; bus3.req_addr = 32'h8000_0004;
        step();
        bus3.req_valid = 1'b0;
        step();
        step();
        chk_bit("rmid_mem_valid", bus3.rsp_valid, 1'b1);
        chk_word("rmid_mem_kept", bus3.rsp_inst, W1);
        step();

        // ---- randomized traffic on LATENCY=1 against the model ----
        exp_q.delete();
        for (int cyc = 0; cyc < 600; cyc++) begin
            chk_bit("rnd_rsp_valid", bus1.rsp_valid, exp_q.size() != 0);
            chk_bit("rnd_req_ready", bus1.req_ready, exp_q.size() < 2);
            if (exp_q.size() != 0) begin
                chk_bit("rnd_rsp_err", bus1.rsp_err, exp_q[0][32]);
                chk_word("rnd_rsp_inst", bus1.rsp_inst, exp_q[0][31:0]);
            end
            if (cyc < 596) begin
                bus1.req_valid = ($urandom_range(0, 3) != 0);
                bus1.req_addr  = pick_addr();
                bus1.rsp_ready = ($urandom_range(0, 3) != 0);
                bus1.load_en   = ($urandom_range(0, 4) == 0);
                bus1.load_addr = pick_addr();
                bus1.load_data = $urandom;
            end else begin
                bus1.req_valid = 1'b0;
                bus1.rsp_ready = 1'b1;
                bus1.load_en   = 1'b0;
            end
            acc     = bus1.req_valid && (exp_q.size() < 2);
            fetched = ref_fetch(bus1.req_addr);
            if (bus1.rsp_ready && exp_q.size() != 0) begin
                void'(exp_q.pop_front());
            end
            if (acc) begin
                exp_q.push_back(fetched);
            end
            if (bus1.load_en) begin
                model_load(bus1.load_addr, bus1.load_data);
            end
            step();
        end
        chk_bit("rnd_final_empty", bus1.rsp_valid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
